// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths, FSM state encoding and address/block helpers for
// the direct-mapped write-back data cache.
//   ADDR_W     CPU byte address width
//   INDEX_W    set index width (2^INDEX_W lines)
//   OFFSET_W   byte offset width inside a 4-byte block
//   TAG_W      tag width stored per line
//   BLOCK_W    line/block width in bits
//   BLK_ADDR_W memory block address width {tag,index}
package dcache_pkg;

    localparam int ADDR_W     = 8;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int BLOCK_W    = 32;
    localparam int BLK_ADDR_W = ADDR_W - OFFSET_W;
    localparam int NUM_LINES  = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W-1:0];
    endfunction

    // Byte 0 of a block lives in bits [7:0].
    function automatic logic [7:0] select_byte(input logic [BLOCK_W-1:0] blk,
                                               input logic [OFFSET_W-1:0] off);
        logic [BLOCK_W-1:0] shifted;
        shifted = blk >> {off, 3'd0};
        return shifted[7:0];
    endfunction

    function automatic logic [BLOCK_W-1:0] merge_byte(input logic [BLOCK_W-1:0] blk,
                                                      input logic [OFFSET_W-1:0] off,
                                                      input logic [7:0]          b);
        logic [BLOCK_W-1:0] merged;
        merged = blk;
        merged[{off, 3'd0} +: 8] = b;
        return merged;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: line storage for the cache (data, tag, valid, dirty).
//   CLK, RESET      clock, synchronous active-high reset (clears valid/dirty only)
//   index           line selected for read, byte write and fill
//   rd_block/rd_tag/rd_valid/rd_dirty  combinational read of the selected line
//   byte_we, byte_offset, byte_data    store one byte into the line, mark dirty
//   fill_we, fill_tag, fill_block      load a whole block, mark valid and clean
module dcache_array
    import dcache_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic [INDEX_W-1:0]  index,
    output logic [BLOCK_W-1:0]  rd_block,
    output logic [TAG_W-1:0]    rd_tag,
    output logic                rd_valid,
    output logic                rd_dirty,
    input  logic                byte_we,
    input  logic [OFFSET_W-1:0] byte_offset,
    input  logic [7:0]          byte_data,
    input  logic                fill_we,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [BLOCK_W-1:0]  fill_block
);

    logic [BLOCK_W-1:0]   data_r [NUM_LINES];
    logic [TAG_W-1:0]     tag_r  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_r;
    logic [NUM_LINES-1:0] dirty_r;

    assign rd_block = data_r[index];
    assign rd_tag   = tag_r[index];
    assign rd_valid = valid_r[index];
    assign rd_dirty = dirty_r[index];

    // Data and tag storage: not reset, a fill replaces the block, a store merges a byte.
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            data_r[index] <= fill_block;
            tag_r[index]  <= fill_tag;
        end else if (byte_we) begin
            data_r[index] <= merge_byte(data_r[index], byte_offset, byte_data);
        end
    end

    // Line status bits: reset invalidates everything, dropping any dirty data.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_r <= '0;
            dirty_r <= '0;
        end else if (fill_we) begin
            valid_r[index] <= 1'b1;
            dirty_r[index] <= 1'b0;
        end else if (byte_we) begin
            dirty_r[index] <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate byte data cache.
//   CLK, RESET     clock, synchronous active-high reset
//   READ, WRITE    CPU load/store request, held while BUSYWAIT is high (WRITE wins)
//   ADDRESS        byte address {tag[7:5], index[4:2], offset[1:0]}
//   WRITEDATA      store byte
//   READDATA       load byte, valid while READ high and BUSYWAIT low
//   BUSYWAIT       CPU stall
//   MEM_READ/MEM_WRITE          block fetch / write-back request (registered)
//   MEM_ADDRESS/MEM_WRITEDATA   block address and write-back block (registered)
//   MEM_READDATA, MEM_BUSYWAIT  fetched block and memory busy (low = done this cycle)
module dcache
    import dcache_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_W-1:0]     ADDRESS,
    input  logic [7:0]            WRITEDATA,
    output logic [7:0]            READDATA,
    output logic                  BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [BLK_ADDR_W-1:0] MEM_ADDRESS,
    output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0]    MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    state_t                  state_r;
    logic                    mem_read_r;
    logic                    mem_write_r;
    logic [BLK_ADDR_W-1:0]   mem_addr_r;
    logic [BLOCK_W-1:0]      mem_wdata_r;

    logic [TAG_W-1:0]        tag_s;
    logic [INDEX_W-1:0]      index_s;
    logic [OFFSET_W-1:0]     offset_s;
    logic [BLOCK_W-1:0]      line_block_s;
    logic [TAG_W-1:0]        line_tag_s;
    logic                    line_valid_s;
    logic                    line_dirty_s;
    logic                    hit_s;
    logic                    req_s;
    logic                    busy_s;
    logic                    byte_we_s;
    logic                    fill_we_s;

    assign tag_s    = addr_tag(ADDRESS);
    assign index_s  = addr_index(ADDRESS);
    assign offset_s = addr_offset(ADDRESS);
    assign req_s    = READ | WRITE;
    assign hit_s    = line_valid_s & (line_tag_s == tag_s);

    // The CPU holds ADDRESS through a miss, so its index also addresses the fill;
    // the fill tag comes from the registered block address for a stable source.
    dcache_array u_array (
        .CLK         (CLK),
        .RESET       (RESET),
        .index       (index_s),
        .rd_block    (line_block_s),
        .rd_tag      (line_tag_s),
        .rd_valid    (line_valid_s),
        .rd_dirty    (line_dirty_s),
        .byte_we     (byte_we_s),
        .byte_offset (offset_s),
        .byte_data   (WRITEDATA),
        .fill_we     (fill_we_s),
        .fill_tag    (mem_addr_r[BLK_ADDR_W-1 -: TAG_W]),
        .fill_block  (MEM_READDATA)
    );

    // Stall, store-commit and fill strobes decoded from the current state.
    always_comb begin
        busy_s    = 1'b1;
        byte_we_s = 1'b0;
        fill_we_s = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s    = req_s & ~hit_s;
                byte_we_s = WRITE & hit_s & ~RESET;
            end
            WRITEBACK: begin
                busy_s = 1'b1;
            end
            FETCH: begin
                busy_s    = 1'b1;
                fill_we_s = ~MEM_BUSYWAIT & ~RESET;
            end
            default: begin
                busy_s = 1'b1;
            end
        endcase
    end

    // Miss-handling FSM; memory request signals are registered alongside the state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= IDLE;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s && !hit_s) begin
                        if (line_valid_s && line_dirty_s) begin
                            state_r     <= WRITEBACK;
                            mem_write_r <= 1'b1;
                            mem_addr_r  <= {line_tag_s, index_s};
                            mem_wdata_r <= line_block_s;
                        end else begin
                            state_r    <= FETCH;
                            mem_read_r <= 1'b1;
                            mem_addr_r <= {tag_s, index_s};
                        end
                    end
                end
                WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        state_r     <= FETCH;
                        mem_write_r <= 1'b0;
                        mem_read_r  <= 1'b1;
                        mem_addr_r  <= {tag_s, index_s};
                    end
                end
                FETCH: begin
                    if (!MEM_BUSYWAIT) begin
                        state_r    <= IDLE;
                        mem_read_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                end
            endcase
        end
    end

    assign READDATA      = select_byte(line_block_s, offset_s);
    assign BUSYWAIT      = busy_s;
    assign MEM_READ      = mem_read_r;
    assign MEM_WRITE     = mem_write_r;
    assign MEM_ADDRESS   = mem_addr_r;
    assign MEM_WRITEDATA = mem_wdata_r;

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed scoreboard bench for dcache with a simple block memory model
// (5 busy cycles per fetch, 3 per write-back).
module tb_dcache;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [7:0]  ADDRESS = 8'h00;
    logic [7:0]  WRITEDATA = 8'h00;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    dcache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       is_read;
        logic [7:0] data;
    } cpu_exp_t;

    typedef struct packed {
        logic        is_write;
        logic [5:0]  addr;
        logic [31:0] data;
    } mem_exp_t;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Block memory model
    logic [31:0] mem [64];
    int          busy_cnt = 0;

    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (busy_cnt != (MEM_WRITE ? 3 : 5));
    assign MEM_READDATA = mem[MEM_ADDRESS];

    always @(posedge CLK) begin
        if (RESET || !(MEM_READ | MEM_WRITE)) begin
            busy_cnt <= 0;
        end else if (!MEM_BUSYWAIT) begin
            busy_cnt <= 0;
            if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
        end else begin
            busy_cnt <= busy_cnt + 1;
        end
    end

    // CPU response monitor: one completion per request, on the cycle BUSYWAIT is low.
    always @(negedge CLK) begin
        cpu_exp_t e;
        if (!RESET && (READ || WRITE) && !BUSYWAIT) begin
            if (cpu_q.size() == 0) begin
                check("cpu_unexpected_completion", 32'd1, 32'd0);
            end else begin
                e = cpu_q.pop_front();
                check("cpu_is_read", {31'd0, READ && !WRITE}, {31'd0, e.is_read});
                if (e.is_read) check("readdata", {24'd0, READDATA}, {24'd0, e.data});
            end
        end
    end

    // Memory transaction monitor: new request pops an expectation; held requests stay stable.
    logic        prev_rd = 1'b0;
    logic        prev_wr = 1'b0;
    logic [5:0]  cur_addr = 6'd0;
    logic [31:0] cur_wdata = 32'd0;
    always @(negedge CLK) begin
        mem_exp_t m;
        if (!RESET) begin
            if (MEM_READ && MEM_WRITE) check("mem_rd_wr_together", 32'd1, 32'd0);
            if ((MEM_READ && !prev_rd) || (MEM_WRITE && !prev_wr)) begin
                if (mem_q.size() == 0) begin
                    check("mem_unexpected_request", {26'd0, MEM_ADDRESS}, 32'hFFFFFFFF);
                end else begin
                    m = mem_q.pop_front();
                    check("mem_is_write", {31'd0, MEM_WRITE}, {31'd0, m.is_write});
                    check("mem_address", {26'd0, MEM_ADDRESS}, {26'd0, m.addr});
                    if (m.is_write) check("mem_writedata", MEM_WRITEDATA, m.data);
                end
                cur_addr  = MEM_ADDRESS;
                cur_wdata = MEM_WRITEDATA;
            end else if ((MEM_READ && prev_rd) || (MEM_WRITE && prev_wr)) begin
                if (MEM_ADDRESS !== cur_addr)
                    check("mem_address_stable", {26'd0, MEM_ADDRESS}, {26'd0, cur_addr});
                if (MEM_WRITE && MEM_WRITEDATA !== cur_wdata)
                    check("mem_writedata_stable", MEM_WRITEDATA, cur_wdata);
            end
        end
        prev_rd = MEM_READ;
        prev_wr = MEM_WRITE;
    end

    task automatic exp_mem(input logic wr, input logic [5:0] addr, input logic [31:0] data);
        mem_q.push_back('{wr, addr, data});
    endtask

    // Issue one CPU request (called just after a rising edge) and check its stall length.
    task automatic cpu_op(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_rd,
                          input int exp_stall);
        int  stall;
        bit  done;
        cpu_q.push_back('{rd && !wr, exp_rd});
        READ      = rd;
        WRITE     = wr;
        ADDRESS   = addr;
        WRITEDATA = wdata;
        stall = 0;
        done  = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge CLK);
            if (BUSYWAIT) stall++;
            else done = 1'b1;
        end
        if (!done) check("cpu_timeout", 32'd1, 32'd0);
        @(posedge CLK);
        #1;
        READ  = 1'b0;
        WRITE = 1'b0;
        check("stall_cycles", stall, exp_stall);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[6'h01] = 32'hDDCCBBAA;
        mem[6'h09] = 32'h44332211;
        mem[6'h20] = 32'h0F0E0D0C;
        mem[6'h28] = 32'h13579BDF;

        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        check("reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
        check("reset_mem_read", {31'd0, MEM_READ}, 32'd0);
        check("reset_mem_write", {31'd0, MEM_WRITE}, 32'd0);

        // Clean read miss, then hits on the same block
        exp_mem(1'b0, 6'h01, 32'h0);
        cpu_op(1'b1, 1'b0, 8'h05, 8'h00, 8'hBB, 7);
        cpu_op(1'b1, 1'b0, 8'h04, 8'h00, 8'hAA, 0);
        cpu_op(1'b1, 1'b0, 8'h06, 8'h00, 8'hCC, 0);
        cpu_op(1'b1, 1'b0, 8'h07, 8'h00, 8'hDD, 0);

        // Write hit, read back
        cpu_op(1'b0, 1'b1, 8'h05, 8'h5A, 8'h00, 0);
        cpu_op(1'b1, 1'b0, 8'h05, 8'h00, 8'h5A, 0);

        // Dirty conflict miss: write-back then fetch
        exp_mem(1'b1, 6'h01, 32'hDDCC5AAA);
        exp_mem(1'b0, 6'h09, 32'h0);
        cpu_op(1'b1, 1'b0, 8'h25, 8'h00, 8'h22, 11);

        // Write miss on a clean (invalid) line: allocate and merge
        exp_mem(1'b0, 6'h20, 32'h0);
        cpu_op(1'b0, 1'b1, 8'h80, 8'h77, 8'h00, 7);
        cpu_op(1'b1, 1'b0, 8'h80, 8'h00, 8'h77, 0);
        cpu_op(1'b1, 1'b0, 8'h81, 8'h00, 8'h0D, 0);

        // The merged line must be dirty: evicting it writes the merged block back
        exp_mem(1'b1, 6'h20, 32'h0F0E0D77);
        exp_mem(1'b0, 6'h28, 32'h0);
        cpu_op(1'b1, 1'b0, 8'hA0, 8'h00, 8'hDF, 11);

        // Reset in the middle of a fetch aborts it
        exp_mem(1'b0, 6'h11, 32'h0);
        READ    = 1'b1;
        ADDRESS = 8'h44;
        repeat (3) @(negedge CLK);
        check("fetch_mem_read", {31'd0, MEM_READ}, 32'd1);
        check("fetch_busywait", {31'd0, BUSYWAIT}, 32'd1);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        READ  = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        check("abort_mem_read", {31'd0, MEM_READ}, 32'd0);
        check("abort_mem_write", {31'd0, MEM_WRITE}, 32'd0);
        check("abort_busywait", {31'd0, BUSYWAIT}, 32'd0);

        // Line 1 was invalidated by reset: misses again (memory holds the written-back block)
        exp_mem(1'b0, 6'h01, 32'h0);
        cpu_op(1'b1, 1'b0, 8'h04, 8'h00, 8'hAA, 7);

        // READ and WRITE together behave as a store
        cpu_op(1'b1, 1'b1, 8'h04, 8'h99, 8'h00, 0);
        cpu_op(1'b1, 1'b0, 8'h04, 8'h00, 8'h99, 0);

        repeat (3) @(posedge CLK);
        check("cpu_queue_empty", cpu_q.size(), 32'd0);
        check("mem_queue_empty", mem_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-back, write-allocate data cache. It sits between the CPU datapath and the block-wide data memory. It serves byte loads and stores from the CPU, stalling the CPU through BUSYWAIT. That BUSYWAIT is the stall the register file and PC already honour: they hold state on any edge where BUSYWAIT is high. On a miss the cache issues block reads and write-backs to memory, and handles the memory's own busywait handshake.

## Interface
- ADDR_W, 8, CPU byte address width
- INDEX_W, 3, set index width (2^INDEX_W lines)
- OFFSET_W, 2, byte offset within block (block = 4 bytes = 32 bits, fixed)
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- READ  in  1  CPU load request, held until BUSYWAIT low
- WRITE  in  1  CPU store request, held until BUSYWAIT low
- ADDRESS  in  ADDR_W  byte address: tag [7:5], index [4:2], offset [1:0]
- WRITEDATA  in  8  store byte
- READDATA  out  8  load byte, valid while READ high and BUSYWAIT low
- BUSYWAIT  out  1  CPU stall
- MEM_READ  out  1  block fetch request
- MEM_WRITE  out  1  block write-back request
- MEM_ADDRESS  out  ADDR_W-OFFSET_W  block address {tag,index}
- MEM_WRITEDATA  out  32  write-back block, byte 0 in [7:0]
- MEM_READDATA  in  32  fetched block, byte 0 in [7:0]
- MEM_BUSYWAIT  in  1  memory busy; low means transfer done this cycle

## Operation
- Per line: 32-bit data, tag (ADDR_W-INDEX_W-OFFSET_W bits), valid, dirty.
- hit = valid[index] & (tag[index] == ADDRESS tag), combinational.
- States: IDLE, WRITEBACK, FETCH.
- IDLE, no request: BUSYWAIT=0, MEM_READ=MEM_WRITE=0.
- IDLE, read hit: READDATA = the addressed byte, combinational. BUSYWAIT=0.
- IDLE, write hit: BUSYWAIT=0. At the edge, the byte is written and dirty is set.
- IDLE, miss:
  - BUSYWAIT=1 combinationally in the same cycle.
  - Next state is WRITEBACK if the line is valid and dirty, else FETCH.
- WRITEBACK:
  - MEM_WRITE=1, MEM_ADDRESS={stored tag,index}, MEM_WRITEDATA=stored block.
  - At the first edge with MEM_BUSYWAIT=0 after entry, go to FETCH.
- FETCH:
  - MEM_READ=1, MEM_ADDRESS={ADDRESS tag,index}.
  - At the first edge with MEM_BUSYWAIT=0 after entry: write MEM_READDATA into the line, load tag, set valid=1, clear dirty, go to IDLE.
- After a fill, IDLE re-evaluates the held request, which now hits. The store merges into the fetched block and sets dirty.
- BUSYWAIT = (READ|WRITE) & ~(state==IDLE & hit). It is also 1 in WRITEBACK and FETCH regardless of request.
- READ and WRITE both high: treated as WRITE.
- Request dropped mid-miss: the miss sequence still completes (line filled), then the cache returns to IDLE.
- RESET:
  - Clears all valid and dirty bits, state → IDLE, MEM_READ=MEM_WRITE=0.
  - Data and tag arrays are not cleared.
- RESET mid-miss aborts the memory transaction. Dirty data is lost.

## Timing
- Outputs after reset: BUSYWAIT=0 (absent request), MEM_READ=0, MEM_WRITE=0. READDATA, MEM_ADDRESS and MEM_WRITEDATA are don't-care.
- Hit latency: read data same cycle; store committed at the next edge.
- Clean miss: 1 (IDLE→FETCH) + Lm edges, where Lm = memory busy cycles + 1. The hit is served in the following cycle.
- Dirty miss: 1 + Lw + Lm edges.
- MEM_READ, MEM_WRITE, MEM_ADDRESS and MEM_WRITEDATA are registered/state-decoded. They are stable for the whole transaction and never asserted together.
- The CPU must hold ADDRESS, WRITEDATA, READ and WRITE stable while BUSYWAIT=1.

## Structure
- Package dcache_pkg:
  - state enum (IDLE=2'd0, WRITEBACK=2'd1, FETCH=2'd2)
  - width localparams TAG_W = ADDR_W-INDEX_W-OFFSET_W and BLOCK_W = 32
  - field-extraction helpers
- Sub-module dcache_array:
  - data, tag, valid and dirty storage with combinational read
  - byte-write port and block-fill port
  - synchronous clear of valid/dirty on RESET
- The top level holds the FSM, hit logic and byte select.

## Test plan
- Reset, then READ ADDRESS=0x05, memory returns 0xDDCCBBAA after 5 busy cycles. Required: BUSYWAIT high, MEM_READ with MEM_ADDRESS=0x01 until fill, then READDATA=0xBB and BUSYWAIT=0 in the next cycle.
- Re-read 0x04, 0x06, 0x07. Required: zero-cycle hits returning 0xAA, 0xCC, 0xDD, with no MEM_READ.
- WRITE 0x5A to 0x05 (hit). Required: no stall. A subsequent READ 0x05 returns 0x5A, and the dirty bit of line 1 is set.
- READ 0x25 (same index, tag 1). Required: MEM_WRITE with MEM_ADDRESS=0x01 and MEM_WRITEDATA=0xDDCC5AAA, then MEM_READ with MEM_ADDRESS=0x09, then hit.
- WRITE miss to 0x80 with 0x77 on a clean line. Required: fetch of block 0x20, then the merged byte is written and the line is marked dirty.
- Assert RESET during FETCH. Required: MEM_READ drops at that edge, state → IDLE, and a READ 0x04 misses again.
